// File: rtl/axi4_master_device_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_pkg / axi_interface
//  Purpose  : AXI4 field types shared by the traffic-generator master and the
//             network wrapper, plus the five-channel AXI4 bundle with
//             master and slave views.
//  Signals  : AW  awid, awaddr, awlen, awsize, awburst, awvalid, awready
//             W   wdata, wstrb, wlast, wvalid, wready
//             B   bid, bresp, bvalid, bready
//             AR  arid, araddr, arlen, arsize, arburst, arvalid, arready
//             R   rid, rdata, rresp, rlast, rvalid, rready
//  Revision : 1.0  initial release
// ============================================================================

package axi4_pkg;
    typedef logic [31:0] axi_addr_t;
    typedef logic [63:0] axi_data_t;
    typedef logic [3:0]  axi_id_t;
    typedef logic [7:0]  axi_len_t;
    typedef logic [2:0]  axi_size_t;
    typedef logic [1:0]  axi_burst_t;
    typedef logic [1:0]  axi_resp_t;
    typedef logic [7:0]  axi_strb_t;

    localparam axi_burst_t C_BURST_INCR = 2'b01;
endpackage

interface axi_interface;
    import axi4_pkg::*;

    // Write address channel
    axi_id_t    awid;
    axi_addr_t  awaddr;
    axi_len_t   awlen;
    axi_size_t  awsize;
    axi_burst_t awburst;
    logic       awvalid;
    logic       awready;

    // Write data channel
    axi_data_t  wdata;
    axi_strb_t  wstrb;
    logic       wlast;
    logic       wvalid;
    logic       wready;

    // Write response channel
    axi_id_t    bid;
    axi_resp_t  bresp;
    logic       bvalid;
    logic       bready;

    // Read address channel
    axi_id_t    arid;
    axi_addr_t  araddr;
    axi_len_t   arlen;
    axi_size_t  arsize;
    axi_burst_t arburst;
    logic       arvalid;
    logic       arready;

    // Read data channel
    axi_id_t    rid;
    axi_data_t  rdata;
    axi_resp_t  rresp;
    logic       rlast;
    logic       rvalid;
    logic       rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

`default_nettype wire

// File: rtl/axi4_master_device.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_master_device
//  Purpose  : AXI4 burst traffic generator. A start pulse launches one INCR
//             burst of BURST_LEN 64-bit beats at a word index. Write beats
//             carry DATA_BASE+i; read beats are captured into rdata[], which
//             wraps modulo MEM_DEPTH. Write and read engines are independent.
//  Ports    : CLK          rising-edge clock
//             RST_N        synchronous reset, active HIGH (legacy name)
//             axi          AXI4 master view of axi_interface
//             start_read   one-cycle pulse, launches a read burst
//             start_write  one-cycle pulse, launches a write burst
//             addr         word index of the first beat, sampled with start
//  Revision : 1.0  initial release
// ============================================================================

module axi4_master_device #(
    parameter int                  ID        = 0,
    parameter int                  BURST_LEN = 8,
    parameter int                  MEM_DEPTH = 64,
    parameter axi4_pkg::axi_data_t DATA_BASE = 64'hDEADBEEFDEADBEEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    axi_interface.master        axi,
    input  logic                start_read,
    input  logic                start_write,
    input  axi4_pkg::axi_addr_t addr
);
    import axi4_pkg::*;

    // Beat counter must be able to hold BURST_LEN itself: the read engine
    // keeps counting up to that value to flag surplus beats.
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] c_BURST_LEN = CNT_W'(BURST_LEN);
    localparam logic [IDX_W-1:0] c_IDX_MAX   = IDX_W'(MEM_DEPTH - 1);
    localparam axi_size_t        c_SIZE_8B   = 3'd3;

    // Write engine states
    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_ADDR = 2'd1;
    localparam logic [1:0] c_W_DATA = 2'd2;
    localparam logic [1:0] c_W_RESP = 2'd3;

    // Read engine states
    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_ADDR = 2'd1;
    localparam logic [1:0] c_R_DATA = 2'd2;

    // ------------------------------------------------------------------
    // Captured read data, inspected hierarchically by benches.
    // ------------------------------------------------------------------
    axi_data_t rdata [MEM_DEPTH];

    // Write engine registers
    logic [1:0]       r_wstate;
    axi_addr_t        r_awaddr;
    logic             r_awvalid;
    logic             r_wvalid;
    logic             r_wlast;
    axi_data_t        r_wdata;
    logic [CNT_W-1:0] r_wbeat;
    logic             r_bready;

    // Read engine registers
    logic [1:0]       r_rstate;
    axi_addr_t        r_araddr;
    logic             r_arvalid;
    logic             r_rready;
    logic [CNT_W-1:0] r_rbeat;
    logic [IDX_W-1:0] r_ridx;

    logic [CNT_W-1:0] w_wbeat_nxt;
    logic [IDX_W-1:0] w_addr_idx;
    logic [IDX_W-1:0] w_ridx_nxt;

    assign w_wbeat_nxt = r_wbeat + CNT_W'(1);

    // Storage index of the first read beat; later beats step a wrapping
    // pointer instead of recomputing the modulo every beat.
    assign w_addr_idx  = IDX_W'(addr % 32'(MEM_DEPTH));
    assign w_ridx_nxt  = (r_ridx == c_IDX_MAX) ? '0 : r_ridx + IDX_W'(1);

    // ------------------------------------------------------------------
    // Channel outputs: all VALID/READY/LAST/DATA come straight from flops.
    // ------------------------------------------------------------------
    assign axi.awid    = axi_id_t'(ID);
    assign axi.awaddr  = r_awaddr;
    assign axi.awlen   = axi_len_t'(BURST_LEN - 1);
    assign axi.awsize  = c_SIZE_8B;
    assign axi.awburst = C_BURST_INCR;
    assign axi.awvalid = r_awvalid;

    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = '1;
    assign axi.wlast   = r_wlast;
    assign axi.wvalid  = r_wvalid;

    assign axi.bready  = r_bready;

    assign axi.arid    = axi_id_t'(ID);
    assign axi.araddr  = r_araddr;
    assign axi.arlen   = axi_len_t'(BURST_LEN - 1);
    assign axi.arsize  = c_SIZE_8B;
    assign axi.arburst = C_BURST_INCR;
    assign axi.arvalid = r_arvalid;

    assign axi.rready  = r_rready;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            r_wstate  <= c_W_IDLE;
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_wdata   <= '0;
            r_wbeat   <= '0;
            r_bready  <= 1'b0;
        end else begin
            case (r_wstate)
                c_W_IDLE: begin
                    if (start_write) begin
                        r_awaddr  <= addr;
                        r_awvalid <= 1'b1;
                        r_wstate  <= c_W_ADDR;
                    end
                end
                c_W_ADDR: begin
                    // WVALID only rises after the AW handshake.
                    if (axi.awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wbeat   <= '0;
                        r_wdata   <= DATA_BASE;
                        r_wlast   <= (c_LAST_BEAT == '0);
                        r_wstate  <= c_W_DATA;
                    end
                end
                c_W_DATA: begin
                    if (axi.wready) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_bready <= 1'b1;
                            r_wstate <= c_W_RESP;
                        end else begin
                            // Beat data is prepared one beat ahead so the
                            // data path stays fully registered.
                            r_wbeat <= w_wbeat_nxt;
                            r_wdata <= DATA_BASE + axi_data_t'(w_wbeat_nxt);
                            r_wlast <= (w_wbeat_nxt == c_LAST_BEAT);
                        end
                    end
                end
                c_W_RESP: begin
                    // Response code is not inspected; no retry on error.
                    if (axi.bvalid) begin
                        r_bready <= 1'b0;
                        r_wstate <= c_W_IDLE;
                    end
                end
                default: r_wstate <= c_W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read engine and capture array
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            r_rstate  <= c_R_IDLE;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_rbeat   <= '0;
            r_ridx    <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                rdata[i] <= '0;
            end
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (start_read) begin
                        r_araddr  <= addr;
                        r_ridx    <= w_addr_idx;
                        r_arvalid <= 1'b1;
                        r_rstate  <= c_R_ADDR;
                    end
                end
                c_R_ADDR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_rbeat   <= '0;
                        r_rstate  <= c_R_DATA;
                    end
                end
                c_R_DATA: begin
                    if (axi.rvalid) begin
                        // Surplus beats beyond BURST_LEN are drained but
                        // dropped; the counter saturates at BURST_LEN.
                        if (r_rbeat < c_BURST_LEN) begin
                            rdata[r_ridx] <= axi.rdata;
                            r_rbeat       <= r_rbeat + CNT_W'(1);
                            r_ridx        <= w_ridx_nxt;
                        end
                        // RLAST always ends the burst, early or not.
                        if (axi.rlast) begin
                            r_rready <= 1'b0;
                            r_rstate <= c_R_IDLE;
                        end
                    end
                end
                default: r_rstate <= c_R_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi4_master_device.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_master_device
//  Purpose  : Directed bench for axi4_master_device with a reactive AXI4
//             slave model (configurable AW stall, WREADY toggling, RLAST
//             position) and hand-computed expected values.
//  Revision : 1.0  initial release
// ============================================================================

module tb_axi4_master_device;
    import axi4_pkg::*;

    localparam int          ID        = 1;
    localparam int          BURST_LEN = 8;
    localparam int          MEM_DEPTH = 64;
    localparam logic [63:0] DB        = 64'hDEADBEEFDEADBEEF;

    logic        CLK         = 1'b0;
    logic        RST_N       = 1'b1;
    logic        start_read  = 1'b0;
    logic        start_write = 1'b0;
    logic [31:0] addr        = '0;

    axi_interface axi ();

    axi4_master_device #(
        .ID        (ID),
        .BURST_LEN (BURST_LEN),
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_BASE (DB)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .axi         (axi),
        .start_read  (start_read),
        .start_write (start_write),
        .addr        (addr)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Slave model: decides READY/VALID at the falling edge, then logs the
    // handshakes that the next rising edge will complete.
    // ------------------------------------------------------------------
    bit          sl_reset     = 1'b1;
    int          aw_stall_cfg = 0;
    bit          tog_en       = 1'b0;
    int          r_last_cfg   = 7;

    int          aw_wait, aw_stall_cycles;
    bit          tog, b_pend, r_active;
    int          r_idx, w_ptr;
    int          aw_count, w_count, b_count, ar_count, r_count, rl_count;
    int          stab_err, strb_err;
    logic [31:0] aw_addr_l, ar_addr_l, p_awaddr;
    logic [7:0]  aw_len_l, ar_len_l;
    logic [2:0]  aw_size_l;
    logic [3:0]  aw_id_l, ar_id_l;
    logic [1:0]  aw_burst_l;
    logic [63:0] wlog [16];
    logic        wlast_log [16];
    logic [63:0] smem [64];
    bit          p_aw_stall, p_w_stall;
    logic [63:0] p_wdata;
    logic        p_wlast;

    always @(negedge CLK) begin
        if (sl_reset) begin
            aw_wait = aw_stall_cfg; aw_stall_cycles = 0;
            tog = 1'b0; b_pend = 1'b0; r_active = 1'b0; r_idx = 0; w_ptr = 0;
            aw_count = 0; w_count = 0; b_count = 0; ar_count = 0; r_count = 0; rl_count = 0;
            stab_err = 0; strb_err = 0; p_aw_stall = 1'b0; p_w_stall = 1'b0;
            for (int i = 0; i < 64; i++) smem[i] = '0;
            for (int i = 0; i < 16; i++) begin wlog[i] = '0; wlast_log[i] = 1'b0; end
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.arready = 1'b0;
            axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0;
            axi.bid = '0; axi.bresp = '0; axi.rid = '0; axi.rresp = '0;
        end else begin
            // Anything stalled last cycle must be held unchanged now.
            if (p_aw_stall && (!axi.awvalid || axi.awaddr != p_awaddr)) stab_err++;
            if (p_w_stall && (!axi.wvalid || axi.wdata != p_wdata || axi.wlast != p_wlast)) stab_err++;

            if (axi.awvalid && aw_wait > 0) begin axi.awready = 1'b0; aw_wait--; end
            else axi.awready = 1'b1;
            axi.wready  = tog_en ? tog : 1'b1;
            tog         = ~tog;
            axi.bvalid  = b_pend;
            axi.bid     = 4'(ID);
            axi.bresp   = 2'b00;
            axi.arready = 1'b1;
            axi.rvalid  = r_active;
            axi.rid     = 4'(ID);
            axi.rresp   = 2'b00;
            axi.rdata   = DB + 64'(r_idx);
            axi.rlast   = r_active && (r_idx == r_last_cfg);

            if (axi.awvalid && axi.awready) begin
                aw_count++;
                aw_addr_l = axi.awaddr; aw_len_l = axi.awlen; aw_size_l = axi.awsize;
                aw_id_l = axi.awid; aw_burst_l = axi.awburst;
                w_ptr = int'(axi.awaddr);
            end
            if (axi.wvalid && axi.wready) begin
                if (w_count < 16) begin wlog[w_count] = axi.wdata; wlast_log[w_count] = axi.wlast; end
                smem[w_ptr % 64] = axi.wdata;
                if (axi.wstrb != 8'hFF) strb_err++;
                w_ptr++; w_count++;
                if (axi.wlast) b_pend = 1'b1;
            end
            if (axi.bvalid && axi.bready) begin b_pend = 1'b0; b_count++; end
            if (axi.rvalid && axi.rready) begin
                r_count++;
                if (axi.rlast) begin r_active = 1'b0; r_idx = 0; rl_count++; end
                else r_idx++;
            end
            if (axi.arvalid && axi.arready) begin
                ar_count++; ar_addr_l = axi.araddr; ar_len_l = axi.arlen; ar_id_l = axi.arid;
                r_active = 1'b1; r_idx = 0;
            end

            p_aw_stall = axi.awvalid && !axi.awready;
            if (p_aw_stall) aw_stall_cycles++;
            p_awaddr   = axi.awaddr;
            p_w_stall  = axi.wvalid && !axi.wready;
            p_wdata    = axi.wdata;
            p_wlast    = axi.wlast;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic sl_clear();
        @(negedge CLK); sl_reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK); sl_reset = 1'b0;
    endtask

    task automatic pulse(input bit w, input bit r, input logic [31:0] a);
        @(negedge CLK); addr = a; start_write = w; start_read = r;
        @(negedge CLK); start_write = 1'b0; start_read = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int wb, input int rb);
        bit done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (b_count >= wb && rl_count >= rb) begin done = 1'b1; break; end
            @(negedge CLK);
        end
        repeat (4) @(negedge CLK);
        check_eq(tag, 64'(done), 64'd1);
    endtask

    task automatic check_wburst(input string tag, input int base);
        check_eq({tag, "_aw_count"}, 64'(aw_count), 64'd1);
        check_eq({tag, "_awaddr"}, 64'(aw_addr_l), 64'(base));
        check_eq({tag, "_w_count"}, 64'(w_count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("%s_wdata%0d", tag, i), wlog[i], DB + 64'(i));
            check_eq($sformatf("%s_wlast%0d", tag, i), 64'(wlast_log[i]), 64'(i == 7));
            check_eq($sformatf("%s_smem%0d", tag, base + i), smem[(base + i) % 64], DB + 64'(i));
        end
    endtask

    task automatic check_rburst(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_rdata%0d", tag, (base + i) % 64), dut.rdata[(base + i) % 64], DB + 64'(i));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        check_eq("rst_awvalid", 64'(axi.awvalid), 64'd0);
        check_eq("rst_wvalid",  64'(axi.wvalid),  64'd0);
        check_eq("rst_wlast",   64'(axi.wlast),   64'd0);
        check_eq("rst_arvalid", 64'(axi.arvalid), 64'd0);
        check_eq("rst_bready",  64'(axi.bready),  64'd0);
        check_eq("rst_rready",  64'(axi.rready),  64'd0);
        check_eq("rst_rdata0",  dut.rdata[0],  64'd0);
        check_eq("rst_rdata63", dut.rdata[63], 64'd0);

        // Write burst at index 2
        sl_clear();
        pulse(1'b1, 1'b0, 32'd2);
        check_eq("wr_aw_latency", 64'(axi.awvalid), 64'd1);
        wait_done("wr_done", 1, 0);
        check_wburst("wr", 2);
        check_eq("wr_awlen",   64'(aw_len_l),   64'd7);
        check_eq("wr_awsize",  64'(aw_size_l),  64'd3);
        check_eq("wr_awid",    64'(aw_id_l),    64'd1);
        check_eq("wr_awburst", 64'(aw_burst_l), 64'd1);
        check_eq("wr_wstrb",   64'(strb_err),   64'd0);
        check_eq("wr_idle",    64'(axi.bready), 64'd0);

        // Read burst at index 3
        sl_clear();
        pulse(1'b0, 1'b1, 32'd3);
        wait_done("rd_done", 0, 1);
        check_eq("rd_ar_count", 64'(ar_count), 64'd1);
        check_eq("rd_araddr",   64'(ar_addr_l), 64'd3);
        check_eq("rd_arlen",    64'(ar_len_l),  64'd7);
        check_eq("rd_arid",     64'(ar_id_l),   64'd1);
        check_rburst("rd", 3, 8);
        check_eq("rd_rdata2",  dut.rdata[2],  64'd0);
        check_eq("rd_rdata11", dut.rdata[11], 64'd0);

        // Backpressure: AW stalled 5 cycles, WREADY toggling, plus an
        // ignored second start_write while the burst is in progress.
        aw_stall_cfg = 5; tog_en = 1'b1;
        sl_clear();
        pulse(1'b1, 1'b0, 32'd10);
        repeat (10) @(negedge CLK);
        pulse(1'b1, 1'b0, 32'd99);
        wait_done("bp_done", 1, 0);
        repeat (10) @(negedge CLK);
        check_wburst("bp", 10);
        check_eq("bp_aw_stall",  64'(aw_stall_cycles), 64'd5);
        check_eq("bp_stability", 64'(stab_err), 64'd0);

        // Concurrent read and write from the same start cycle
        aw_stall_cfg = 0; tog_en = 1'b0;
        sl_clear();
        pulse(1'b1, 1'b1, 32'd30);
        wait_done("cc_done", 1, 1);
        check_wburst("cc", 30);
        check_eq("cc_ar_count", 64'(ar_count), 64'd1);
        check_rburst("cc", 30, 8);

        // Read wrapping the capture array: 62, 63, 0..5
        sl_clear();
        pulse(1'b0, 1'b1, 32'd62);
        wait_done("wrap_done", 0, 1);
        check_rburst("wrap", 62, 8);
        check_eq("wrap_rdata61", dut.rdata[61], 64'd0);

        // Early RLAST on beat 4
        r_last_cfg = 3;
        sl_clear();
        pulse(1'b0, 1'b1, 32'd20);
        wait_done("early_done", 0, 1);
        check_rburst("early", 20, 4);
        for (int i = 24; i < 28; i++)
            check_eq($sformatf("early_rdata%0d", i), dut.rdata[i], 64'd0);
        check_eq("early_r_count", 64'(r_count), 64'd4);
        check_eq("early_idle",    64'(axi.rready), 64'd0);

        // Surplus beats (10) after a full burst are drained, not stored
        r_last_cfg = 9;
        sl_clear();
        pulse(1'b0, 1'b1, 32'd40);
        wait_done("long_done", 0, 1);
        check_rburst("long", 40, 8);
        check_eq("long_rdata48", dut.rdata[48], 64'd0);
        check_eq("long_rdata49", dut.rdata[49], 64'd0);
        check_eq("long_r_count", 64'(r_count), 64'd10);

        // Reset in the middle of a write data phase
        r_last_cfg = 7; tog_en = 1'b1;
        sl_clear();
        pulse(1'b1, 1'b1, 32'd50);
        for (int c = 0; c < 50 && !axi.wvalid; c++) @(negedge CLK);
        check_eq("mid_in_wdata", 64'(axi.wvalid), 64'd1);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1; sl_reset = 1'b1;
        @(negedge CLK);
        RST_N = 1'b0;
        check_eq("mid_awvalid", 64'(axi.awvalid), 64'd0);
        check_eq("mid_wvalid",  64'(axi.wvalid),  64'd0);
        check_eq("mid_wlast",   64'(axi.wlast),   64'd0);
        check_eq("mid_arvalid", 64'(axi.arvalid), 64'd0);
        check_eq("mid_bready",  64'(axi.bready),  64'd0);
        check_eq("mid_rready",  64'(axi.rready),  64'd0);
        check_eq("mid_rdata3",  dut.rdata[3],  64'd0);
        check_eq("mid_rdata40", dut.rdata[40], 64'd0);
        check_eq("mid_rdata50", dut.rdata[50], 64'd0);
        tog_en = 1'b0;
        sl_clear();
        pulse(1'b1, 1'b0, 32'd4);
        wait_done("post_done", 1, 0);
        check_wburst("post", 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi4_master_device.md
Name: axi4_master_device

Overview:
- AXI4 burst-traffic-generator master that drives one master port of the ideal AXI4 network wrapper. A start pulse launches one fixed 8-beat INCR write burst or read burst at a given word index.
- Write data is a fixed incrementing pattern. Read data is captured into an internal array named rdata, which benches inspect hierarchically.
- Read and write engines are independent and may run concurrently.

Parameters:
- ID, 0, AXI transaction ID driven on AWID/ARID; also the expected BID/RID.
- BURST_LEN, 8, beats per burst; AxLEN = BURST_LEN-1.
- MEM_DEPTH, 64, entries in rdata; index wraps modulo MEM_DEPTH.
- DATA_BASE, 64'hDEADBEEFDEADBEEF, write pattern base; beat i carries DATA_BASE+i.

Ports:
- CLK  input  1  sole clock, rising-edge.
- RST_N  input  1  Synchronous, active-high reset; the port name is kept for codebase compatibility.
- axi  interface  axi_interface (master side)  AW/W/B/AR/R channels. Address 32b (axi_addr_t), data 64b (axi_data_t), ID/LEN/SIZE/BURST/RESP/STRB/LAST/VALID/READY per axi4_pkg.
- start_read  input  1  one-cycle pulse launching a read burst.
- start_write  input  1  one-cycle pulse launching a write burst.
- addr  input  32  word index of the first beat; sampled on the accepted start pulse.

Behaviour:
- Reset (RST_N high at posedge), from any state:
  - AWVALID, WVALID, WLAST, ARVALID, BREADY, RREADY = 0.
  - Beat counters = 0; both FSMs return to IDLE.
  - All rdata entries = 0.
  - Any in-flight burst is abandoned.
- Address phase constants: AxSIZE = 3 (8 bytes), AxBURST = INCR, AxLEN = BURST_LEN-1, AxID = ID. AxADDR = latched addr.
- Write FSM:
  - W_IDLE: on start_write, latch addr and go to W_ADDR. A pulse while not idle is ignored.
  - W_ADDR: AWVALID=1, held stable until AWREADY. Handshake -> W_DATA, beat count w=0.
  - W_DATA: WVALID=1, WDATA = DATA_BASE+w, WSTRB = all ones, WLAST = (w==BURST_LEN-1). Each WVALID&WREADY advances w. Handshake on the last beat -> W_RESP.
  - W_RESP: BREADY=1. On BVALID -> W_IDLE. BRESP is ignored; no retry.
  - WVALID is never raised before the AW handshake completes.
- Read FSM:
  - R_IDLE: on start_read, latch addr and go to R_ADDR.
  - R_ADDR: ARVALID=1 until ARREADY, then go to R_DATA with beat count r=0.
  - R_DATA: RREADY=1.
    - Each RVALID beat with r<BURST_LEN: write RDATA to rdata[(addr+r) mod MEM_DEPTH], then r++.
    - Beats with r≥BURST_LEN are accepted but not stored.
    - RLAST -> R_IDLE. An early RLAST ends the burst with the remaining entries unchanged.
- start_read and start_write in the same cycle: both engines start independently.
- Outputs are registered; no combinational path from READY to VALID.
- Latency: AWVALID/ARVALID asserts the cycle after the start pulse. With READY held high throughout, a write completes AW + 8 W beats + B in ≥10 cycles after the start cycle.
- rdata is never cleared except by reset.

Test Plan:
- Write burst to an ideal slave: addr=2, start_write pulse, AWREADY/WREADY/BVALID responsive -> AWADDR=2, AWLEN=7, AWSIZE=3, AWID=ID. W beats carry 0xDEADBEEFDEADBEEF…0xDEADBEEFDEADBEF6. WLAST only on beat 8. Slave buffer[2..9] = DATA_BASE+0..7.
- Read burst: addr=3, ID=1, slave returns DATA_BASE+i on 8 beats with RLAST on the last -> rdata[3..10] = DATA_BASE+0..7; ARID=1, ARLEN=7.
- Backpressure: AWREADY held low 5 cycles, WREADY toggling each cycle -> AWADDR/AWVALID stable while stalled. WDATA is held stable while stalled and advances only on handshakes. Exactly 8 beats are sent.
- Concurrent/ignored starts: start_read and start_write in the same cycle -> both bursts complete. A second start_write mid-burst -> no extra AW issued.
- Wrap and early end: addr=62 with MEM_DEPTH=64 -> beats land at 62, 63, 0..5. RLAST on beat 4 -> only 4 entries written and the FSM returns to idle.
- Reset mid-burst: assert RST_N during W_DATA -> next cycle all VALIDs are 0 and rdata is cleared. A new start_write then runs a clean 8-beat burst.
